xrv_bit_scan_iter: RTL
======================

Name: xrv_bit_scan_iter

Overview:
- Sequential successor to the combinational find-first-one.
- Accepts a bit vector through a valid/ready handshake, then emits the index of every set bit, one per cycle, on a valid/ready output stream.
- Scan direction (LSB-first or MSB-first) and a wrap-around start position (round-robin) are chosen per vector.
- Consumers: load/store-multiple register walkers, interrupt-pending scanners, round-robin requester arbitration.

Parameters:
- DATA_WIDTH_P, 32, vector width; any value >= 2, power of two not required.
- IDX_W_P, $clog2(DATA_WIDTH_P), index width; derived, never overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  vector offered
- in_ready_o  out  1  block can accept a vector (high only in IDLE)
- in_data_i  in  DATA_WIDTH_P  vector to scan
- in_msb_first_i  in  1  0 = ascending scan, 1 = descending scan
- in_start_i  in  IDX_W_P  first position examined; wraps
- flush_i  in  1  synchronous abort
- out_valid_o  out  1  out_idx_o is valid
- out_ready_i  in  1  consumer takes index
- out_idx_o  out  IDX_W_P  index of the current set bit
- out_last_o  out  1  current index is the final one of this vector
- empty_o  out  1  one-cycle pulse: accepted vector was all-zero
- busy_o  out  1  in SCAN

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE, pending register 0, direction 0, pointer 0, out_valid_o 0, out_idx_o 0, out_last_o 0, empty_o 0, busy_o 0, in_ready_o 1.
- States: IDLE and SCAN.
- IDLE, on in_valid_i & in_ready_o:
  - If in_data_i == 0: stay in IDLE and pulse empty_o for exactly the next cycle.
  - Otherwise: capture in_data_i into pending, latch direction and start, go to SCAN.
- Input latency: the first index is valid the cycle after acceptance.
- SCAN: out_valid_o = 1.
  - out_idx_o = first set bit of pending, searching from start in the latched direction with wrap.
  - Ascending order: start, start+1 .. W-1, 0 .. start-1.
  - Descending order: start, start-1 .. 0, W-1 .. start+1.
- Start pointer is latched per vector. It does not advance between emitted indices: cleared bits simply drop out of the search.
- Out-of-range start (>= DATA_WIDTH_P, only possible when W is not a power of two) is treated as 0 when ascending and as W-1 when descending.
- Output handshake (out_valid_o & out_ready_i):
  - Clear that bit in pending.
  - If it was the last (out_last_o = 1, i.e. popcount(pending) == 1), return to IDLE next cycle.
- Throughput: one index per cycle under continuous out_ready_i. A vector with N set bits holds the block for N cycles, plus 1 idle cycle before the next vector is accepted (no in/out overlap).
- Stability: while out_valid_o & !out_ready_i, out_idx_o and out_last_o hold.
- All outputs are functions of registers only; there is no combinational path from any input to any output.
- Outside SCAN: out_idx_o = 0 and out_last_o = 0.
- flush_i (highest priority below reset):
  - Next state IDLE, pending cleared, no empty_o pulse.
  - A same-cycle output handshake is discarded.
  - A same-cycle input offer is not accepted; in_ready_o is not gated combinationally, but acceptance is suppressed.
- Reset mid-SCAN: immediate return to reset values; the partial sequence is lost.
- in_ready_o = (state == IDLE).

Decomposition:
- Package xrv_bitscan_pkg:
  - state enum scan_state_e {SCAN_IDLE, SCAN_ACTIVE};
  - direction constants SCAN_LSB_FIRST = 1'b0, SCAN_MSB_FIRST = 1'b1.
- One combinational sub-module, xrv_ff_one_rr, parametrised by DATA_WIDTH_P.
  - Inputs: in, start, msb_first. Outputs: idx, no_ones, one_hot_count_is_one.
  - Implementation: two masked find-first trees (positions at/after start, and positions before start in scan direction); the first tree wins when non-empty.
  - Descending mode bit-reverses the vector and the index.
- Top level holds the FSM, pending register and handshakes.

Test Plan:
- W=8, ascending, start=0, in_data=0b1010_0101, out_ready held 1 -> indices 0,2,5,7 on consecutive cycles; out_last on 7; in_ready 1 the cycle after.
- W=8, ascending, start=6, same vector -> order 7,0,2,5. Descending, start=3, same vector -> order 2,0,7,5.
- W=8, in_data=0 accepted -> no out_valid; empty_o high exactly one cycle; in_ready stays 1.
- W=32, in_data=0x8000_0001, out_ready toggling 0,1,0,1 -> out_idx_o held at 0 while stalled; then 31 with out_last; exactly 2 handshakes.
- W=8, in_data=0xFF, flush_i asserted on the 3rd index with out_ready=1 -> only 2 handshakes counted; next cycle IDLE, pending 0, no empty pulse. Repeat with rst_ni pulled low mid-scan -> all outputs at reset values asynchronously.
- W=5 (non power of two), start=7, ascending, in_data=0b10010 -> start treated as 0, order 1,4. Descending, start=7 -> treated as 4, order 4,1.

Source files
------------

// File: rtl/xrv_bitscan_pkg.sv
// Shared types and constants for the sequential bit-scan iterator.
package xrv_bitscan_pkg;

  typedef enum logic {
    SCAN_IDLE,
    SCAN_ACTIVE
  } scan_state_e;

  localparam logic SCAN_LSB_FIRST = 1'b0;
  localparam logic SCAN_MSB_FIRST = 1'b1;

endpackage

// File: rtl/xrv_ff_one_rr.sv
// Round-robin find-first-one: first set bit at or after start in scan direction, wrapping.
// Purely combinational; no handshake.
module xrv_ff_one_rr
  import xrv_bitscan_pkg::*;
#(
  parameter int DATA_WIDTH_P = 32,
  parameter int IDX_W_P      = $clog2(DATA_WIDTH_P)
) (
  input  logic [DATA_WIDTH_P-1:0] in_i,
  input  logic [IDX_W_P-1:0]      start_i,
  input  logic                    msb_first_i,
  output logic [IDX_W_P-1:0]      idx_o,
  output logic                    no_ones_o,
  output logic                    one_hot_count_is_one_o
);

  localparam logic [IDX_W_P-1:0] LAST_IDX  = IDX_W_P'(DATA_WIDTH_P - 1);
  localparam logic [IDX_W_P:0]   WIDTH_EXT = (IDX_W_P + 1)'(DATA_WIDTH_P);

  logic                    start_oor;
  logic [DATA_WIDTH_P-1:0] vec;
  logic [IDX_W_P-1:0]      st;
  logic [DATA_WIDTH_P-1:0] hi_mask;
  logic [DATA_WIDTH_P-1:0] hi_vec;
  logic [DATA_WIDTH_P-1:0] lo_vec;
  logic [DATA_WIDTH_P-1:0] sel_vec;
  logic [IDX_W_P-1:0]      pos;

  // Descending scans run the same ascending search on the bit-reversed vector;
  // an out-of-range start maps to reversed position 0 (original W-1) either way.
  always_comb begin
    start_oor = ({1'b0, start_i} >= WIDTH_EXT);
    vec       = in_i;
    st        = start_oor ? '0 : start_i;
    if (msb_first_i == SCAN_MSB_FIRST) begin
      for (int i = 0; i < DATA_WIDTH_P; i++) begin
        vec[i] = in_i[DATA_WIDTH_P-1-i];
      end
      st = start_oor ? '0 : (LAST_IDX - start_i);
    end

    hi_mask = {DATA_WIDTH_P{1'b1}} << st;
    hi_vec  = vec & hi_mask;
    lo_vec  = vec & ~hi_mask;
    sel_vec = (hi_vec != '0) ? hi_vec : lo_vec;

    pos = '0;
    for (int i = DATA_WIDTH_P - 1; i >= 0; i--) begin
      if (sel_vec[i]) begin
        pos = IDX_W_P'(i);
      end
    end

    idx_o = (msb_first_i == SCAN_MSB_FIRST) ? (LAST_IDX - pos) : pos;
  end

  assign no_ones_o              = (in_i == '0);
  assign one_hot_count_is_one_o = (in_i != '0) && ((in_i & (in_i - 1'b1)) == '0);

endmodule

// File: rtl/xrv_bit_scan_iter.sv
// Accepts a vector, then streams the index of every set bit one per cycle (first index 1 cycle after accept).
// Output holds under !out_ready_i; input is accepted only in IDLE; flush_i aborts synchronously.
module xrv_bit_scan_iter
  import xrv_bitscan_pkg::*;
#(
  parameter int DATA_WIDTH_P = 32,
  parameter int IDX_W_P      = $clog2(DATA_WIDTH_P)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH_P-1:0] in_data_i,
  input  logic                    in_msb_first_i,
  input  logic [IDX_W_P-1:0]      in_start_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [IDX_W_P-1:0]      out_idx_o,
  output logic                    out_last_o,
  output logic                    empty_o,
  output logic                    busy_o
);

  localparam logic [DATA_WIDTH_P-1:0] ONE_BIT = DATA_WIDTH_P'(1);

  scan_state_e             state_q, state_d;
  logic [DATA_WIDTH_P-1:0] pending_q, pending_d;
  logic                    dir_q, dir_d;
  logic [IDX_W_P-1:0]      start_q, start_d;
  logic                    empty_q, empty_d;

  logic [IDX_W_P-1:0]      ff_idx;
  logic                    ff_no_ones;
  logic                    ff_last;

  xrv_ff_one_rr #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .IDX_W_P      (IDX_W_P)
  ) u_ff_one_rr (
    .in_i                   (pending_q),
    .start_i                (start_q),
    .msb_first_i            (dir_q),
    .idx_o                  (ff_idx),
    .no_ones_o              (ff_no_ones),
    .one_hot_count_is_one_o (ff_last)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    start_d   = start_q;
    empty_d   = 1'b0;

    if (flush_i) begin
      state_d   = SCAN_IDLE;
      pending_d = '0;
    end else begin
      unique case (state_q)
        SCAN_IDLE: begin
          if (in_valid_i) begin
            if (in_data_i == '0) begin
              empty_d = 1'b1;
            end else begin
              pending_d = in_data_i;
              dir_d     = in_msb_first_i;
              start_d   = in_start_i;
              state_d   = SCAN_ACTIVE;
            end
          end
        end
        SCAN_ACTIVE: begin
          if (ff_no_ones) begin
            state_d = SCAN_IDLE;
          end else if (out_ready_i) begin
            pending_d = pending_q & ~(ONE_BIT << ff_idx);
            if (ff_last) begin
              state_d = SCAN_IDLE;
            end
          end
        end
        default: state_d = SCAN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SCAN_IDLE;
      pending_q <= '0;
      dir_q     <= SCAN_LSB_FIRST;
      start_q   <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      start_q   <= start_d;
      empty_q   <= empty_d;
    end
  end

  assign busy_o      = (state_q == SCAN_ACTIVE);
  assign in_ready_o  = (state_q == SCAN_IDLE);
  assign out_valid_o = busy_o;
  assign out_idx_o   = busy_o ? ff_idx : '0;
  assign out_last_o  = busy_o & ff_last;
  assign empty_o     = empty_q;

endmodule
